// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: hex glyph table and index sizing.
package seg7_pkg;

  // Active-high {CA,CB,CC,CD,CE,CF,CG} patterns for hex digits 0..F
  localparam logic [6:0] SEG7_HEX_LUT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  function automatic int seg7_idx_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG7_HEX_LUT[nibble_i];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with PWM brightness and
// frame-synchronous double-buffered display contents.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_W      = 14,
  parameter int BRIGHT_W    = 4,
  parameter bit AN_ACT_LOW  = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load_valid,
  output logic                    o_load_ready,
  input  logic [4*NUM_DIGITS-1:0] i_data,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
  input  logic [BRIGHT_W-1:0]     i_bright,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame_start
);

  localparam int IDX_W = seg7_idx_width(NUM_DIGITS);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACT_LOW}};
  localparam logic [6:0]            SEG_OFF  = {7{SEG_ACT_LOW}};

  logic [SCAN_W-1:0]       phase_q, phase_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    pend_q;
  logic [4*NUM_DIGITS-1:0] pend_data_q, act_data_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q, act_dp_q;
  logic [NUM_DIGITS-1:0]   pend_en_q, act_en_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_q;

  logic       slot_end;
  logic       boundary;
  logic       accept;
  logic       on;
  logic [3:0] nibble;
  logic [6:0] seg_raw;

  always_comb begin
    slot_end = &phase_q;
    boundary = slot_end && (idx_q == LAST_IDX);
    accept   = i_load_valid && !pend_q;
    phase_d  = phase_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = boundary ? '0 : idx_q + 1'b1;
    end
  end

  assign nibble = act_data_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_decode (
    .nibble_i (nibble),
    .seg_o    (seg_raw)
  );

  // Polarity is folded in here so the pins toggle straight from flops
  always_comb begin
    on    = act_en_q[idx_q] && (phase_q[SCAN_W-1 -: BRIGHT_W] < i_bright);
    an_d  = (on ? (NUM_DIGITS'(1) << idx_q) : '0) ^ AN_OFF;
    seg_d = (on ? seg_raw : 7'h00) ^ SEG_OFF;
    dp_d  = (on && act_dp_q[idx_q]) ^ SEG_ACT_LOW;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_en_q   <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      act_en_q    <= '0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
      dp_q        <= SEG_ACT_LOW;
      frame_q     <= 1'b0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= boundary;
      // Capture needs an empty pending slot and commit needs a full one, so they never collide
      if (accept) begin
        pend_q      <= 1'b1;
        pend_data_q <= i_data;
        pend_dp_q   <= i_dp;
        pend_en_q   <= i_digit_en;
      end else if (boundary && pend_q) begin
        pend_q     <= 1'b0;
        act_data_q <= pend_data_q;
        act_dp_q   <= pend_dp_q;
        act_en_q   <= pend_en_q;
      end
    end
  end

  assign o_load_ready  = !pend_q;
  assign o_an          = an_q;
  assign o_seg         = seg_q;
  assign o_dp          = dp_q;
  assign o_frame_start = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 4 digits, 16-cycle slots, 2-bit brightness.
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        loadValid;
  logic        loadReady;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  en;
  logic [1:0]  bright;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dpOut;
  logic        frameStart;

  int errors;
  int checks;

  int         onCnt [4];
  logic [6:0] segOn [4];
  logic       dpOn  [4];
  int         badCnt;
  int         fsCnt;
  int         fsLast;

  seg7_scan_ctrl #(
    .NUM_DIGITS (4),
    .SCAN_W     (4),
    .BRIGHT_W   (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_load_valid  (loadValid),
    .o_load_ready  (loadReady),
    .i_data        (data),
    .i_dp          (dp),
    .i_digit_en    (en),
    .i_bright      (bright),
    .o_an          (an),
    .o_seg         (seg),
    .o_dp          (dpOut),
    .o_frame_start (frameStart)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic waitFrame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frameStart && n < 200);
    if (!frameStart) checkOutput("frame_timeout", 32'd0, 32'd1);
  endtask

  // Index i of the scan is slot i/16, phase i%16 relative to the last frame pulse
  task automatic scanFrame(input int ncyc);
    int slot;
    logic [3:0] expAn;
    for (int k = 0; k < 4; k++) begin
      onCnt[k] = 0;
      segOn[k] = 7'h7F;
      dpOn[k]  = 1'b1;
    end
    badCnt = 0;
    fsCnt  = 0;
    fsLast = -1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      slot  = (i / 16) % 4;
      expAn = ~(4'b0001 << slot);
      if (an != 4'hF) begin
        if (an == expAn) begin
          onCnt[slot]++;
          segOn[slot] = seg;
          dpOn[slot]  = dpOut;
        end else begin
          badCnt++;
        end
      end else if (seg != 7'h7F || dpOut != 1'b1) begin
        badCnt++;
      end
      if (frameStart) begin
        fsCnt++;
        fsLast = i;
      end
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] e,
                               input logic [3:0] p, input logic [1:0] b);
    data      = d;
    en        = e;
    dp        = p;
    bright    = b;
    loadValid = 1'b1;
  endtask

  initial begin
    int n;
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    loadValid = 1'b0;
    data      = '0;
    dp        = '0;
    en        = '0;
    bright    = 2'd3;

    // Reset state and blank first frame
    repeat (3) @(negedge clk);
    checkOutput("rst_an", an, 4'hF);
    checkOutput("rst_seg", seg, 7'h7F);
    checkOutput("rst_dp", dpOut, 1);
    checkOutput("rst_ready", loadReady, 1);
    checkOutput("rst_fs", frameStart, 0);
    rst = 1'b0;
    scanFrame(70);
    checkOutput("blank1_on", onCnt[0] + onCnt[1] + onCnt[2] + onCnt[3], 0);
    checkOutput("blank1_bad", badCnt, 0);
    checkOutput("blank1_fs_cnt", fsCnt, 1);
    checkOutput("blank1_fs_pos", fsLast, 63);

    // First load, full brightness code 3
    applyStimulus(16'h3210, 4'hF, 4'b0100, 2'd3);
    checkOutput("load1_ready", loadReady, 1);
    @(negedge clk);
    loadValid = 1'b0;
    checkOutput("load1_pending", loadReady, 0);
    waitFrame();
    checkOutput("load1_ready_after", loadReady, 1);
    scanFrame(64);
    checkOutput("t2_on0", onCnt[0], 12);
    checkOutput("t2_seg0", segOn[0], 7'b0000001);
    checkOutput("t2_dp0", dpOn[0], 1);
    checkOutput("t2_on2", onCnt[2], 12);
    checkOutput("t2_seg2", segOn[2], 7'b0010010);
    checkOutput("t2_dp2", dpOn[2], 0);
    checkOutput("t2_seg3", segOn[3], 7'b0000110);
    checkOutput("t2_bad", badCnt, 0);
    checkOutput("t2_fs_pos", fsLast, 63);

    // Second load stalls behind a pending one
    applyStimulus(16'hABCD, 4'hF, 4'b0000, 2'd3);
    checkOutput("t3_ready_a", loadReady, 1);
    @(negedge clk);
    checkOutput("t3_pending_a", loadReady, 0);
    applyStimulus(16'h5678, 4'hF, 4'b0000, 2'd3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!loadReady && n < 200);
    checkOutput("t3_ready_timeout", loadReady, 1);
    checkOutput("t3_ready_at_frame", frameStart, 1);
    @(negedge clk);
    loadValid = 1'b0;
    checkOutput("t3_pending_b", loadReady, 0);
    checkOutput("t3_an_a0", an, 4'b1110);
    checkOutput("t3_seg_a0", seg, 7'b1000010);
    waitFrame();
    scanFrame(64);
    checkOutput("t3_seg_b0", segOn[0], 7'b0000000);
    checkOutput("t3_seg_b1", segOn[1], 7'b0001111);
    checkOutput("t3_seg_b3", segOn[3], 7'b0100100);
    checkOutput("t3_bad", badCnt, 0);

    // Brightness zero keeps the display dark but frames continue
    bright = 2'd0;
    waitFrame();
    scanFrame(64);
    checkOutput("t4_on", onCnt[0] + onCnt[1] + onCnt[2] + onCnt[3], 0);
    checkOutput("t4_bad", badCnt, 0);
    checkOutput("t4_fs_cnt", fsCnt, 1);
    checkOutput("t4_fs_pos", fsLast, 63);

    // Digit enables 0101 at brightness 2
    applyStimulus(16'h3210, 4'b0101, 4'b0000, 2'd2);
    checkOutput("t5_ready", loadReady, 1);
    @(negedge clk);
    loadValid = 1'b0;
    waitFrame();
    scanFrame(64);
    checkOutput("t5_on0", onCnt[0], 8);
    checkOutput("t5_on1", onCnt[1], 0);
    checkOutput("t5_on2", onCnt[2], 8);
    checkOutput("t5_on3", onCnt[3], 0);
    checkOutput("t5_seg2", segOn[2], 7'b0010010);
    checkOutput("t5_bad", badCnt, 0);

    // Asynchronous reset in the middle of digit 2's slot
    waitFrame();
    repeat (40) @(negedge clk);
    checkOutput("t6_an_before", an, 4'b1011);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_an", an, 4'hF);
    checkOutput("t6_seg", seg, 7'h7F);
    checkOutput("t6_dp", dpOut, 1);
    checkOutput("t6_ready", loadReady, 1);
    checkOutput("t6_fs", frameStart, 0);
    @(negedge clk);
    rst = 1'b0;
    scanFrame(70);
    checkOutput("t6_blank_on", onCnt[0] + onCnt[1] + onCnt[2] + onCnt[3], 0);
    checkOutput("t6_blank_bad", badCnt, 0);
    checkOutput("t6_fs_pos", fsLast, 63);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
